// File: rtl/usb_ep_tx_sched.sv
// usb_ep_tx_sched: per-token IN scheduler steering NUM_EP show-ahead byte sources onto the controller TX port.
// Zero-length-packet termination of exact-multiple transfers is built only with `define USB_TX_ZLP_EN.
module usb_ep_tx_sched #(
    parameter int unsigned NUM_EP = 4,
    parameter int unsigned MPS_HS = 512,
    parameter int unsigned MPS_FS = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   usb_usbrst_i,
    input  logic                   usb_highspeed_i,
    input  logic [3:0]             usb_endpt_i,
    input  logic                   usb_txact_i,
    input  logic                   usb_txpop_i,
    input  logic                   usb_txpktfin_i,
    output logic [7:0]             usb_txdat_o,
    output logic                   usb_txval_o,
    output logic [11:0]            usb_txdat_len_o,
    output logic                   usb_txcork_o,
    input  logic [8*NUM_EP-1:0]    src_dat_i,
    input  logic [12*NUM_EP-1:0]   src_level_i,
    input  logic [NUM_EP-1:0]      src_eot_i,
    output logic [NUM_EP-1:0]      src_pop_o,
    output logic [NUM_EP-1:0]      pkt_done_o,
    output logic [NUM_EP-1:0]      pkt_abort_o,
    output logic                   busy_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_FIN} state_t;

    localparam logic [11:0] MPS_HS_L = 12'(MPS_HS);
    localparam logic [11:0] MPS_FS_L = 12'(MPS_FS);

    state_t            state_q, state_d;
    logic [11:0]       cnt_q, cnt_d;
    logic [11:0]       len_q, len_d;
    logic              cork_q, cork_d;
    logic [3:0]        ep_q, ep_d;
    logic              txact_prev_q;
    logic [NUM_EP-1:0] done_q, done_d;
    logic [NUM_EP-1:0] abort_q, abort_d;

    logic [11:0]       mps;
    logic [11:0]       sel_level;
    logic              sel_eot, sel_valid;
    logic [11:0]       calc_len;
    logic              calc_cork;
    logic [NUM_EP-1:0] ep_hot;
    logic              txval, pop;
    logic [7:0]        txdat;

`ifdef USB_TX_ZLP_EN
    logic [NUM_EP-1:0] zlp_pend_q, zlp_pend_d;
    logic              is_zlp_q, is_zlp_d;
    logic              zlp_cand_q, zlp_cand_d;
    logic [NUM_EP-1:0] sel_hot;
    logic              sel_zlp;
`endif

    assign mps = usb_highspeed_i ? MPS_HS_L : MPS_FS_L;

    // Length/cork candidate for the endpoint currently addressed by the controller.
    always_comb begin
        sel_level = '0;
        sel_eot   = 1'b0;
        sel_valid = 1'b0;
`ifdef USB_TX_ZLP_EN
        sel_hot   = '0;
`endif
        for (int unsigned k = 0; k < NUM_EP; k++) begin
            if (usb_endpt_i == 4'(k + 1)) begin
                sel_level = src_level_i[12*k +: 12];
                sel_eot   = src_eot_i[k];
                sel_valid = 1'b1;
`ifdef USB_TX_ZLP_EN
                sel_hot[k] = 1'b1;
`endif
            end
        end
        calc_len  = (sel_level < mps) ? sel_level : mps;
        calc_cork = !sel_valid || (sel_level == '0) || ((sel_level < mps) && !sel_eot);
        if (!sel_valid) begin
            calc_len = '0;
        end
`ifdef USB_TX_ZLP_EN
        sel_zlp = |(sel_hot & zlp_pend_q);
        if (sel_zlp) begin
            calc_len  = '0;
            calc_cork = 1'b0;
        end
`endif
    end

    always_comb begin
        ep_hot = '0;
        txdat  = '0;
        for (int unsigned k = 0; k < NUM_EP; k++) begin
            if (ep_q == 4'(k + 1)) begin
                ep_hot[k] = 1'b1;
                txdat     = src_dat_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        cork_d  = cork_q;
        ep_d    = ep_q;
        done_d  = '0;
        abort_d = '0;
        txval   = 1'b0;
        pop     = 1'b0;
`ifdef USB_TX_ZLP_EN
        zlp_pend_d = zlp_pend_q;
        is_zlp_d   = is_zlp_q;
        zlp_cand_d = zlp_cand_q;
`endif
        if (state_q == ST_SEND) begin
            txval = (cnt_q < len_q);
            pop   = usb_txpop_i && txval && !usb_usbrst_i;
        end

        if (usb_usbrst_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            len_d   = '0;
            cork_d  = 1'b0;
`ifdef USB_TX_ZLP_EN
            zlp_pend_d = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d  = '0;
                    len_d  = calc_len;
                    cork_d = calc_cork;
                    if (usb_txact_i && !txact_prev_q) begin
                        ep_d    = usb_endpt_i;
                        state_d = ST_LOAD;
`ifdef USB_TX_ZLP_EN
                        is_zlp_d   = sel_zlp;
                        zlp_cand_d = sel_eot && (sel_level == mps) && (calc_len == mps);
`endif
                    end
                end
                default: begin
                    // Completion wins over a simultaneous txact fall; corked tokens never pulse.
                    if (usb_txpktfin_i) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (!cork_q) begin
                            done_d = ep_hot;
`ifdef USB_TX_ZLP_EN
                            if (is_zlp_q) begin
                                zlp_pend_d = zlp_pend_q & ~ep_hot;
                            end else if (zlp_cand_q) begin
                                zlp_pend_d = zlp_pend_q | ep_hot;
                            end
`endif
                        end
                    end else if (!usb_txact_i) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (!cork_q) begin
                            abort_d = ep_hot;
                        end
                    end else begin
                        case (state_q)
                            ST_LOAD: state_d = cork_q ? ST_FIN : ST_SEND;
                            ST_SEND: begin
                                if (pop) begin
                                    cnt_d = cnt_q + 12'd1;
                                end
                                if (cnt_q == len_q) begin
                                    state_d = ST_FIN;
                                end
                            end
                            default: state_d = state_q;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            cork_q       <= 1'b0;
            ep_q         <= '0;
            txact_prev_q <= 1'b0;
            done_q       <= '0;
            abort_q      <= '0;
`ifdef USB_TX_ZLP_EN
            zlp_pend_q   <= '0;
            is_zlp_q     <= 1'b0;
            zlp_cand_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            cork_q       <= cork_d;
            ep_q         <= ep_d;
            txact_prev_q <= usb_txact_i;
            done_q       <= done_d;
            abort_q      <= abort_d;
`ifdef USB_TX_ZLP_EN
            zlp_pend_q   <= zlp_pend_d;
            is_zlp_q     <= is_zlp_d;
            zlp_cand_q   <= zlp_cand_d;
`endif
        end
    end

    assign usb_txdat_o     = (state_q == ST_SEND) ? txdat : '0;
    assign usb_txval_o     = txval;
    assign usb_txdat_len_o = len_q;
    assign usb_txcork_o    = cork_q;
    assign src_pop_o       = pop ? ep_hot : '0;
    assign pkt_done_o      = done_q;
    assign pkt_abort_o     = abort_q;
    assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_ep_tx_sched.sv
// Scoreboard bench for usb_ep_tx_sched: stimulus queues expected pops/pulses, a negedge monitor retires them.
// Build with `define USB_TX_ZLP_EN to exercise the zero-length-packet path.
module tb_usb_ep_tx_sched;
    localparam int NUM_EP = 4;

    logic                 clk = 1'b0;
    logic                 reset_i, usb_usbrst_i, usb_highspeed_i;
    logic [3:0]           usb_endpt_i;
    logic                 usb_txact_i, usb_txpop_i, usb_txpktfin_i;
    logic [7:0]           usb_txdat_o;
    logic                 usb_txval_o;
    logic [11:0]          usb_txdat_len_o;
    logic                 usb_txcork_o;
    logic [8*NUM_EP-1:0]  src_dat_i;
    logic [12*NUM_EP-1:0] src_level_i;
    logic [NUM_EP-1:0]    src_eot_i;
    logic [NUM_EP-1:0]    src_pop_o, pkt_done_o, pkt_abort_o;
    logic                 busy_o;

    usb_ep_tx_sched #(.NUM_EP(4), .MPS_HS(512), .MPS_FS(64)) dut (
        .clk_i(clk), .reset_i(reset_i), .usb_usbrst_i(usb_usbrst_i),
        .usb_highspeed_i(usb_highspeed_i), .usb_endpt_i(usb_endpt_i),
        .usb_txact_i(usb_txact_i), .usb_txpop_i(usb_txpop_i), .usb_txpktfin_i(usb_txpktfin_i),
        .usb_txdat_o(usb_txdat_o), .usb_txval_o(usb_txval_o),
        .usb_txdat_len_o(usb_txdat_len_o), .usb_txcork_o(usb_txcork_o),
        .src_dat_i(src_dat_i), .src_level_i(src_level_i), .src_eot_i(src_eot_i),
        .src_pop_o(src_pop_o), .pkt_done_o(pkt_done_o), .pkt_abort_o(pkt_abort_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] kind;   // 1 pop, 2 done, 3 abort
        logic [3:0] vec;
        logic [7:0] dat;
    } ev_t;

    ev_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  ptr[NUM_EP] = '{0, 0, 0, 0};
    int  exp_ptr[NUM_EP] = '{0, 0, 0, 0};
    int  lvl[NUM_EP] = '{0, 0, 0, 0};
    logic [NUM_EP-1:0] eot = '0;

    function automatic logic [7:0] pat(int ep, int p);
        return 8'(ep * 37 + p);
    endfunction

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Show-ahead source model: head byte advances on each pop.
    always @(posedge clk) begin
        for (int k = 0; k < NUM_EP; k++) begin
            if (src_pop_o[k]) ptr[k] <= ptr[k] + 1;
        end
    end

    always_comb begin
        src_dat_i   = '0;
        src_level_i = '0;
        for (int k = 0; k < NUM_EP; k++) begin
            src_dat_i[8*k +: 8]    = pat(k + 1, ptr[k]);
            src_level_i[12*k +: 12] = 12'(lvl[k]);
        end
        src_eot_i = eot;
    end

    task automatic sb_retire(logic [1:0] kind, logic [3:0] vec, logic [7:0] dat, string name);
        ev_t a, e;
        a = '{kind: kind, vec: vec, dat: dat};
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s unexpected: got 0x%0h expected nothing at %0t", name, int'(a), $time);
        end else begin
            e = sb.pop_front();
            check(name, int'(a), int'(e));
        end
    endtask

    always @(negedge clk) begin
        if (pkt_done_o != '0)  sb_retire(2'd2, pkt_done_o, 8'd0, "pkt_done");
        if (pkt_abort_o != '0) sb_retire(2'd3, pkt_abort_o, 8'd0, "pkt_abort");
        if (src_pop_o != '0)   sb_retire(2'd1, src_pop_o, usb_txdat_o, "src_pop");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic token(int ep, int exp_len, int exp_cork);
        usb_endpt_i = 4'(ep);
        tick();
        check("len", int'(usb_txdat_len_o), exp_len);
        check("cork", int'(usb_txcork_o), exp_cork);
        usb_txact_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic pops(int ep, int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{kind: 2'd1, vec: 4'(1 << (ep - 1)), dat: pat(ep, exp_ptr[ep-1])});
            exp_ptr[ep-1]++;
            usb_txpop_i = 1'b1;
            tick();
        end
        usb_txpop_i = 1'b0;
    endtask

    task automatic finish_pkt(int ep, bit pulse);
        tick();
        usb_txpktfin_i = 1'b1;
        if (pulse) sb.push_back('{kind: 2'd2, vec: 4'(1 << (ep - 1)), dat: 8'd0});
        tick();
        usb_txpktfin_i = 1'b0;
        usb_txact_i    = 1'b0;
        tick();
        check("busy_after_fin", int'(busy_o), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1; usb_usbrst_i = 1'b0; usb_highspeed_i = 1'b1; usb_endpt_i = '0;
        usb_txact_i = 1'b0; usb_txpop_i = 1'b0; usb_txpktfin_i = 1'b0;
        tick(); tick();
        check("rst_txval", int'(usb_txval_o), 0);
        check("rst_len", int'(usb_txdat_len_o), 0);
        check("rst_cork", int'(usb_txcork_o), 0);
        check("rst_txdat", int'(usb_txdat_o), 0);
        check("rst_pop", int'(src_pop_o), 0);
        check("rst_done", int'(pkt_done_o), 0);
        check("rst_abort", int'(pkt_abort_o), 0);
        check("rst_busy", int'(busy_o), 0);
        reset_i = 1'b0;
        tick();

        // HS EP1, 600 bytes, not end-of-transfer: full 512-byte packet, remainder 88 corks.
        lvl[0] = 600; eot[0] = 1'b0;
        token(1, 512, 0);
        check("busy_send", int'(busy_o), 1);
        pops(1, 512);
        finish_pkt(1, 1);
        lvl[0] = 88;
        usb_endpt_i = 4'd1;
        tick();
        check("len_rem", int'(usb_txdat_len_o), 88);
        check("cork_rem", int'(usb_txcork_o), 1);

        // FS EP2, 10-byte short packet; extra pop is ignored.
        usb_highspeed_i = 1'b0;
        lvl[1] = 10; eot[1] = 1'b1;
        token(2, 10, 0);
        pops(2, 10);
        usb_txpop_i = 1'b1;
        check("txval_end", int'(usb_txval_o), 0);
        check("pop_end", int'(src_pop_o), 0);
        usb_txpop_i = 1'b0;
        finish_pkt(2, 1);

        // Invalid endpoints cork without pulses (abort path and pktfin path).
        token(5, 0, 1);
        check("busy_cork", int'(busy_o), 1);
        usb_txact_i = 1'b0;
        tick(); tick();
        check("busy_cork_end", int'(busy_o), 0);
        token(0, 0, 1);
        finish_pkt(1, 0);

        // HS EP3 aborted after 100 bytes; next token continues from popped position.
        usb_highspeed_i = 1'b1;
        lvl[2] = 512; eot[2] = 1'b0;
        token(3, 512, 0);
        pops(3, 100);
        usb_txact_i = 1'b0;
        sb.push_back('{kind: 2'd3, vec: 4'b0100, dat: 8'd0});
        tick(); tick();
        check("busy_abort", int'(busy_o), 0);
        lvl[2] = 700;
        token(3, 512, 0);
        pops(3, 3);
        finish_pkt(3, 1);
        lvl[2] = 40; eot[2] = 1'b1;
        usb_endpt_i = 4'd3;
        tick();
        check("len_ep3", int'(usb_txdat_len_o), 40);
        check("cork_ep3", int'(usb_txcork_o), 0);

        // FS EP1 exact max-packet transfer, then ZLP (or cork without the feature).
        usb_highspeed_i = 1'b0;
        lvl[0] = 64; eot[0] = 1'b1;
        token(1, 64, 0);
        pops(1, 64);
        finish_pkt(1, 1);
        lvl[0] = 0;
`ifdef USB_TX_ZLP_EN
        token(1, 0, 0);
        check("zlp_txval", int'(usb_txval_o), 0);
        finish_pkt(1, 1);
        usb_endpt_i = 4'd1;
        tick();
        check("zlp_clr_cork", int'(usb_txcork_o), 1);
`else
        token(1, 0, 1);
        usb_txact_i = 1'b0;
        tick(); tick();
        check("nozlp_busy", int'(busy_o), 0);
`endif

        // Bus reset mid-packet on HS EP4 at count 30.
        usb_highspeed_i = 1'b1;
        lvl[3] = 100; eot[3] = 1'b1;
        token(4, 100, 0);
        pops(4, 30);
        usb_usbrst_i = 1'b1;
        usb_txpop_i  = 1'b1;
        tick();
        usb_usbrst_i = 1'b0;
        check("usbrst_busy", int'(busy_o), 0);
        check("usbrst_pop", int'(src_pop_o), 0);
        check("usbrst_txval", int'(usb_txval_o), 0);
        usb_txpop_i = 1'b0;
        usb_txact_i = 1'b0;
        tick(); tick();

        // Asynchronous reset mid-packet stops pops without a clock edge.
        usb_highspeed_i = 1'b0;
        lvl[1] = 20; eot[1] = 1'b1;
        token(2, 20, 0);
        pops(2, 5);
        usb_txpop_i = 1'b1;
        reset_i = 1'b1;
        #1;
        check("arst_pop", int'(src_pop_o), 0);
        check("arst_busy", int'(busy_o), 0);
        check("arst_len", int'(usb_txdat_len_o), 0);
        tick();
        usb_txpop_i = 1'b0;
        usb_txact_i = 1'b0;
        reset_i = 1'b0;
        tick(); tick();

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
